// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle core: opcodes, ext fields, condition codes,
// FSM states and flag bit positions.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_LO = 4'd2;
  localparam logic [3:0] CC_HS = 4'd3;
  localparam logic [3:0] CC_LT = 4'd4;
  localparam logic [3:0] CC_GE = 4'd5;
  localparam logic [3:0] CC_AL = 4'd14;

  localparam int FLAG_Z = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  function automatic logic cond_met(input logic [3:0] cc, input logic [2:0] f);
    case (cc)
      CC_EQ:   return f[FLAG_Z];
      CC_NE:   return !f[FLAG_Z];
      CC_LO:   return f[FLAG_L];
      CC_HS:   return !f[FLAG_L];
      CC_LT:   return f[FLAG_N];
      CC_GE:   return !f[FLAG_N];
      CC_AL:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous write port.
module cpu_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RW-1:0]     raddr_a,
  input  logic [RW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

  // NOTE: the array is cleared by reset, so it builds from flops, not a RAM macro;
  // that is intended here because every register must read as zero after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/cpu_core_mc.sv
// Multicycle 16-bit-ISA core: FETCH/DECODE/EXEC/MEM/HALT over one ready/valid
// memory bus, stalling for as long as the memory holds mem_ready low.
module cpu_core_mc
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter int              NREGS    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halted
);

  localparam int RW = $clog2(NREGS);

  state_t            state;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        flags;
  logic [DATA_W-1:0] a_q, b_q;

  logic [3:0] op, cond, ext;
  logic [7:0] imm8;
  logic [RW-1:0] rd_idx, rs_idx;

  assign op     = ir[15:12];
  assign cond   = ir[11:8];
  assign ext    = ir[7:4];
  assign imm8   = ir[7:0];
  assign rd_idx = ir[8 +: RW];
  assign rs_idx = ir[0 +: RW];

  logic [DATA_W-1:0] rd_val, rs_val, operand;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  cpu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rd_idx),
    .wdata   (rf_wdata),
    .raddr_a (rd_idx),
    .raddr_b (rs_idx),
    .rdata_a (rd_val),
    .rdata_b (rs_val)
  );

  logic is_mem;
  assign is_mem = (op == OP_MEM) && (ext == EXT_LOAD || ext == EXT_STOR);

  always_comb begin
    operand = rs_val;
    case (op)
      OP_ADDI, OP_CMPI: operand = DATA_W'($signed(imm8));
      OP_ANDI, OP_MOVI: operand = DATA_W'(imm8);
      default: ;
    endcase
  end

  logic [ADDR_W-1:0] pc_inc, next_pc;
  logic [DATA_W-1:0] alu_res;
  logic              alu_we, flag_we;

  assign pc_inc = pc + ADDR_W'(1);

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_we  = 1'b0;
    flag_we = 1'b0;
    next_pc = pc_inc;
    case (op)
      OP_RTYPE: begin
        alu_we = 1'b1;
        case (ext)
          EXT_ADD: alu_res = a_q + b_q;
          EXT_SUB: alu_res = a_q - b_q;
          EXT_AND: alu_res = a_q & b_q;
          EXT_OR:  alu_res = a_q | b_q;
          EXT_XOR: alu_res = a_q ^ b_q;
          EXT_MOV: alu_res = b_q;
          EXT_CMP: begin alu_we = 1'b0; flag_we = 1'b1; end
          default: alu_we = 1'b0;
        endcase
      end
      OP_ADDI: begin alu_res = a_q + b_q; alu_we = 1'b1; end
      OP_ANDI: begin alu_res = a_q & b_q; alu_we = 1'b1; end
      OP_MOVI: begin alu_res = b_q;       alu_we = 1'b1; end
      OP_CMPI: flag_we = 1'b1;
      OP_MEM: begin
        if (ext == EXT_JAL) begin
          alu_res = DATA_W'(pc_inc);
          alu_we  = 1'b1;
          next_pc = ADDR_W'(b_q);
        end else if (ext == EXT_JCOND && cond_met(cond, flags)) begin
          next_pc = ADDR_W'(b_q);
        end
      end
      OP_BCOND: if (cond_met(cond, flags)) next_pc = pc + ADDR_W'($signed(imm8));
      default: ;
    endcase
  end

  // Only a LOAD leaves mem_we low in MEM, so the two write sources never overlap.
  assign rf_we    = (state == ST_EXEC && alu_we) ||
                    (state == ST_MEM && mem_req && mem_ready && !mem_we);
  assign rf_wdata = (state == ST_MEM) ? mem_rdata : alu_res;
  assign retire   = (state == ST_EXEC && !is_mem) ||
                    (state == ST_MEM && mem_req && mem_ready);
  assign pc_out   = pc;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_FETCH;
      ir        <= '0;
      pc        <= RESET_PC;
      flags     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_req && mem_ready) begin
            ir      <= mem_rdata[15:0];
            mem_req <= 1'b0;
            state   <= ST_DECODE;
          end else if (!mem_req) begin
            // First cycle out of reset: raise the fetch request.
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        ST_DECODE: begin
          a_q   <= rd_val;
          b_q   <= operand;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          pc <= next_pc;
          if (flag_we) begin
            flags[FLAG_Z] <= (a_q == b_q);
            flags[FLAG_L] <= (a_q < b_q);
            flags[FLAG_N] <= ($signed(a_q) < $signed(b_q));
          end
          if (is_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= (ext == EXT_STOR);
            mem_addr  <= ADDR_W'(b_q);
            mem_wdata <= a_q;
            state     <= ST_MEM;
          end else if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= next_pc;
            state    <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (mem_req && mem_ready) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            state    <= ST_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: a 32-bit core on a wait-state memory and a
// 4-register, 8-bit-address core with a nonzero reset PC.
`timescale 1ns/1ps
module tb_cpu_core_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- core A: DATA_W=32, ADDR_W=16, NREGS=16 ----------------
  logic        rst_a, req_a, we_a, ready_a, retire_a, halted_a;
  logic [15:0] addr_a, pc_a;
  logic [31:0] wdata_a, rdata_a;

  cpu_core_mc #(.DATA_W(32), .ADDR_W(16), .NREGS(16), .RESET_PC(16'h0000)) dut_a (
    .clock(clk), .reset(rst_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_rdata(rdata_a), .mem_ready(ready_a), .pc_out(pc_a),
    .retire(retire_a), .halted(halted_a)
  );

  logic [31:0] rom_a [256];
  logic [31:0] st_a  [256];
  logic        stv_a [256];
  int waits_a = 0;
  int wcnt_a;

  assign ready_a = req_a && (wcnt_a >= waits_a);
  assign rdata_a = stv_a[addr_a[7:0]] ? st_a[addr_a[7:0]] : rom_a[addr_a[7:0]];

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      wcnt_a <= 0;
      for (int i = 0; i < 256; i++) stv_a[i] <= 1'b0;
    end else begin
      wcnt_a <= (req_a && !ready_a) ? wcnt_a + 1 : 0;
      if (req_a && ready_a && we_a) begin
        st_a[addr_a[7:0]]  <= wdata_a;
        stv_a[addr_a[7:0]] <= 1'b1;
      end
    end
  end

  // A pending request must hold address, direction and data until accepted.
  int          bus_viol = 0;
  logic        pend = 1'b0;
  logic        p_we;
  logic [15:0] p_addr;
  logic [31:0] p_wd;
  always @(negedge clk) begin
    if (!rst_a) pend <= 1'b0;
    else begin
      if (pend && (!req_a || addr_a != p_addr || we_a != p_we || wdata_a != p_wd))
        bus_viol <= bus_viol + 1;
      pend   <= req_a && !ready_a;
      p_addr <= addr_a;
      p_we   <= we_a;
      p_wd   <= wdata_a;
    end
  end

  function automatic logic [31:0] reg_a(input int i);
    return dut_a.u_regfile.regs[i];
  endfunction

  // ---------------- core B: DATA_W=16, ADDR_W=8, NREGS=4, RESET_PC=0x20 ----------------
  logic        rst_b, req_b, we_b, ready_b, retire_b, halted_b;
  logic [7:0]  addr_b, pc_b;
  logic [15:0] wdata_b, rdata_b;

  cpu_core_mc #(.DATA_W(16), .ADDR_W(8), .NREGS(4), .RESET_PC(8'h20)) dut_b (
    .clock(clk), .reset(rst_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ready(ready_b), .pc_out(pc_b),
    .retire(retire_b), .halted(halted_b)
  );

  logic [15:0] rom_b [256];
  logic [15:0] st_b  [256];
  assign ready_b = req_b;
  assign rdata_b = rom_b[addr_b];
  always @(posedge clk) if (req_b && ready_b && we_b) st_b[addr_b] <= wdata_b;

  // ---------------- helpers ----------------
  task automatic hold_a();
    rst_a = 1'b0;
    for (int i = 0; i < 256; i++) rom_a[i] = 32'h0;
  endtask

  task automatic release_a(input int waits);
    waits_a = waits;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic wait_retire_a(input int n, output int at);
    int got = 0;
    int t = 0;
    at = 0;
    while (got < n && t < 300) begin
      @(negedge clk);
      t++;
      if (retire_a) begin
        got++;
        at = cyc;
      end
    end
    if (got < n) check("retire_timeout", got, n);
  endtask

  task automatic wait_halt_a();
    int t = 0;
    while (!halted_a && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("halted_a", halted_a, 1);
  endtask

  task automatic branch_case(input string tag, input logic [7:0] cmp_imm,
                             input logic [15:0] br, input logic [15:0] exp_pc);
    int t;
    hold_a();
    rom_a[0]     = 32'hD105;               // MOVI r1,0x05
    rom_a[1]     = {16'h0, 8'hB1, cmp_imm}; // CMPI r1,imm
    rom_a[2]     = 32'hD210;               // MOVI r2,0x10
    rom_a[3]     = 32'h4EC2;               // J always r2
    rom_a[8'h10] = {16'h0, br};
    rom_a[8'h0D] = 32'hF000;
    rom_a[8'h11] = 32'hF000;
    release_a(0);
    wait_retire_a(5, t);
    @(posedge clk); #1;
    check(tag, pc_a, exp_pc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, t2, guard, idle_viol, nz;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // ALU sequence, zero-wait memory
    hold_a();
    rom_a[0] = 32'hD105;  // MOVI r1,0x05
    rom_a[1] = 32'hD2FF;  // MOVI r2,0xFF
    rom_a[2] = 32'h0152;  // ADD  r1,r2
    rom_a[3] = 32'hF000;  // HALT
    @(negedge clk); #1;
    check("rst_req", req_a, 0);
    check("rst_pc", pc_a, 16'h0000);
    check("rst_addr", addr_a, 16'h0000);
    check("rst_wdata", wdata_a, 32'h0);
    check("rst_retire", retire_a, 0);
    check("rst_halted", halted_a, 0);
    release_a(0);
    wait_retire_a(1, t0);
    wait_retire_a(1, t1);
    wait_retire_a(1, t2);
    check("alu_interval1", t1 - t0, 3);
    check("alu_interval2", t2 - t1, 3);
    @(posedge clk); #1;
    check("add_r1", reg_a(1), 32'h0000_0104);
    check("movi_r2", reg_a(2), 32'h0000_00FF);
    wait_halt_a();
    idle_viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_a || retire_a || !halted_a) idle_viol++;
    end
    check("halt_quiet", idle_viol, 0);

    // Immediate extension at DATA_W=32, SUB wrap
    hold_a();
    rom_a[0] = 32'h5380;  // ADDI r3,0x80  -> sign-extended
    rom_a[1] = 32'hD380;  // MOVI r3,0x80  -> zero-extended
    rom_a[2] = 32'h13F0;  // ANDI r3,0xF0
    rom_a[3] = 32'hD401;  // MOVI r4,0x01
    rom_a[4] = 32'h0493;  // SUB  r4,r3
    rom_a[5] = 32'hF000;
    release_a(0);
    wait_retire_a(1, t0); @(posedge clk); #1;
    check("addi_sext", reg_a(3), 32'hFFFF_FF80);
    wait_retire_a(1, t0); @(posedge clk); #1;
    check("movi_zext", reg_a(3), 32'h0000_0080);
    wait_retire_a(1, t0); @(posedge clk); #1;
    check("andi", reg_a(3), 32'h0000_0080);
    wait_retire_a(2, t0); @(posedge clk); #1;
    check("sub_wrap", reg_a(4), 32'hFFFF_FF81);

    // Store/load through a memory with 2 wait states on every access
    hold_a();
    rom_a[0] = 32'hD15A;  // MOVI r1,0x5A
    rom_a[1] = 32'hD420;  // MOVI r4,0x20
    rom_a[2] = 32'h4144;  // STOR r1,[r4]
    rom_a[3] = 32'h4504;  // LOAD r5,[r4]
    rom_a[4] = 32'hF000;
    release_a(2);
    wait_retire_a(2, t0);
    wait_retire_a(1, t1);
    // 4 base cycles plus two waits on the fetch and two on the store
    check("stor_cycles", t1 - t0, 8);
    @(posedge clk); #1;
    check("stor_mem", st_a[8'h20], 32'h0000_005A);
    wait_retire_a(1, t2);
    check("load_cycles", t2 - t1, 8);
    @(posedge clk); #1;
    check("load_r5", reg_a(5), 32'h0000_005A);
    check("bus_stable", bus_viol, 0);

    // Conditional branches at PC=0x10 with offset -3
    branch_case("beq_taken",  8'h05, 16'hC0FD, 16'h000D);
    branch_case("bne_not",    8'h05, 16'hC1FD, 16'h0011);
    branch_case("blo_taken",  8'hFF, 16'hC2FD, 16'h000D);
    branch_case("blt_not",    8'hFF, 16'hC4FD, 16'h0011);
    branch_case("bge_taken",  8'hFF, 16'hC5FD, 16'h000D);
    branch_case("bnever_not", 8'h05, 16'hCFFD, 16'h0011);

    // JAL r6,r7 at PC=0x30
    hold_a();
    rom_a[0]     = 32'hD740;  // MOVI r7,0x40
    rom_a[1]     = 32'hD230;  // MOVI r2,0x30
    rom_a[2]     = 32'h4EC2;  // J always r2
    rom_a[8'h30] = 32'h4687;  // JAL r6,r7
    rom_a[8'h40] = 32'hF000;
    release_a(0);
    wait_retire_a(4, t0);
    @(posedge clk); #1;
    check("jal_pc", pc_a, 16'h0040);
    check("jal_link", reg_a(6), 32'h0000_0031);

    // Reset in the middle of a stalled fetch
    hold_a();
    rom_a[0] = 32'hD177;  // MOVI r1,0x77
    rom_a[1] = 32'hF000;
    release_a(3);
    wait_retire_a(1, t0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(req_a && !ready_a) && guard < 20);
    check("fetch_waiting", req_a && !ready_a, 1);
    @(posedge clk); #1;
    check("pre_reset_r1", reg_a(1), 32'h0000_0077);
    #2 rst_a = 1'b0;
    #1;
    check("midrst_req", req_a, 0);
    check("midrst_pc", pc_a, 16'h0000);
    check("midrst_addr", addr_a, 16'h0000);
    nz = 0;
    for (int i = 0; i < 16; i++) if (reg_a(i) != 0) nz++;
    check("midrst_regs", nz, 0);
    @(negedge clk); @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("first_req", req_a, 1);
    check("first_addr", addr_a, 16'h0000);

    // Core B: narrow register fields and nonzero reset PC
    for (int i = 0; i < 256; i++) begin
      rom_b[i] = 16'h0;
      st_b[i]  = 16'h0;
    end
    rom_b[8'h20] = 16'hD6AB;  // MOVI r6 (-> r2),0xAB
    rom_b[8'h21] = 16'hD150;  // MOVI r1,0x50
    rom_b[8'h22] = 16'h4241;  // STOR r2,[r1]
    rom_b[8'h23] = 16'hD551;  // MOVI r5 (-> r1),0x51
    rom_b[8'h24] = 16'h4645;  // STOR r6 (-> r2),[r5 -> r1]
    rom_b[8'h25] = 16'hF000;
    @(negedge clk); #1;
    check("b_rst_pc", pc_b, 8'h20);
    @(negedge clk);
    rst_b = 1'b1;
    guard = 0;
    while (!halted_b && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("b_halted", halted_b, 1);
    check("b_st50", st_b[8'h50], 16'h00AB);
    check("b_st51", st_b[8'h51], 16'h00AB);
    check("b_r2", dut_b.u_regfile.regs[2], 16'h00AB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
